systolic_mm2_ctrl: RTL

SYSTOLIC_MM2_CTRL -- requirements
Module: systolic_mm2_ctrl

---
 rtl/systolic_pkg.sv | 17 +
 rtl/systolic_mm2_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 systolic matrix-multiply controller:
// default operand/result widths and the sequencing FSM states.
package systolic_pkg;

   localparam int W_DEF  = 8;
   localparam int RW_DEF = 2 * W_DEF + 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      FEED0 = 3'd2,
      FEED1 = 3'd3,
      CAPT  = 3'd4,
      DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/systolic_mm2_ctrl.sv
// Sequencer for an external 2x2 outer-product systolic array: captures A/B,
// optionally clears the accumulators, feeds two operand beats, then latches C.
module systolic_mm2_ctrl
   import systolic_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a00,
   input  logic [W-1:0] a01,
   input  logic [W-1:0] a10,
   input  logic [W-1:0] a11,
   input  logic [W-1:0] b00,
   input  logic [W-1:0] b01,
   input  logic [W-1:0] b10,
   input  logic [W-1:0] b11,
   input  logic         in_acc,
   output logic         arr_rst_n,
   output logic [W-1:0] arr_a0,
   output logic [W-1:0] arr_a1,
   output logic [W-1:0] arr_b0,
   output logic [W-1:0] arr_b1,
   input  logic [2*W:0] arr_o1,
   input  logic [2*W:0] arr_o2,
   input  logic [2*W:0] arr_o3,
   input  logic [2*W:0] arr_o4,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [2*W:0] c00,
   output logic [2*W:0] c01,
   output logic [2*W:0] c10,
   output logic [2*W:0] c11,
   output logic         busy
);

   state_t state, next_state;
   logic   accept;

   logic [W-1:0] a00_p0, a01_p0, a10_p0, a11_p0;
   logic [W-1:0] b00_p0, b01_p0, b10_p0, b11_p0;
   logic [W-1:0] sa00, sa01, sa10, sa11, sb00, sb01, sb10, sb11;
   logic [W-1:0] a0_d, a1_d, b0_d, b1_d;

   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = in_acc ? FEED0 : CLR;
         CLR:     next_state = FEED0;
         FEED0:   next_state = FEED1;
         FEED1:   next_state = CAPT;
         CAPT:    next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Stage 0: job operands held for the duration of the job
   always_ff @(posedge clk) begin
      if (accept) begin
         a00_p0 <= a00;  a01_p0 <= a01;  a10_p0 <= a10;  a11_p0 <= a11;
         b00_p0 <= b00;  b01_p0 <= b01;  b10_p0 <= b10;  b11_p0 <= b11;
      end
   end

   // An accumulate job goes straight from IDLE to FEED0, so the first beat
   // must come from the live inputs rather than the not-yet-loaded holding regs.
   always_comb begin
      sa00 = (state == IDLE) ? a00 : a00_p0;
      sa01 = (state == IDLE) ? a01 : a01_p0;
      sa10 = (state == IDLE) ? a10 : a10_p0;
      sa11 = (state == IDLE) ? a11 : a11_p0;
      sb00 = (state == IDLE) ? b00 : b00_p0;
      sb01 = (state == IDLE) ? b01 : b01_p0;
      sb10 = (state == IDLE) ? b10 : b10_p0;
      sb11 = (state == IDLE) ? b11 : b11_p0;
   end

   always_comb begin
      a0_d = '0;
      a1_d = '0;
      b0_d = '0;
      b1_d = '0;
      case (next_state)
         FEED0: begin
            a0_d = sa00;  a1_d = sa10;  b0_d = sb00;  b1_d = sb01;
         end
         FEED1: begin
            a0_d = sa01;  a1_d = sa11;  b0_d = sb10;  b1_d = sb11;
         end
         default: ;
      endcase
   end

   // Stage 1: registered array drive, ready flag and result capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready  <= 1'b0;
         arr_rst_n <= 1'b0;
         arr_a0    <= '0;
         arr_a1    <= '0;
         arr_b0    <= '0;
         arr_b1    <= '0;
         c00       <= '0;
         c01       <= '0;
         c10       <= '0;
         c11       <= '0;
      end else begin
         in_ready  <= (next_state == IDLE);
         arr_rst_n <= (next_state != CLR);
         arr_a0    <= a0_d;
         arr_a1    <= a1_d;
         arr_b0    <= b0_d;
         arr_b1    <= b1_d;
         if (state == CAPT) begin
            c00 <= arr_o1;
            c01 <= arr_o2;
            c10 <= arr_o3;
            c11 <= arr_o4;
         end
      end
   end

endmodule
